decode_imm_stage: RTL and testbench

DECODE_IMM_STAGE -- requirements
Module: decode_imm_stage

---
 rtl/decode_imm_stage.sv | 167 ++++++++++++++++
 tb/tb_decode_imm_stage.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_imm_stage.sv
// RV32I immediate decode into a two-entry skid buffer; a decoded entry appears on out_* the cycle after it is accepted.
// in_ready comes from registered state only, so downstream stalls never reach the input combinationally.
module decode_imm_stage #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_instr,
  input  logic [31:0]        in_pc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_instr,
  output logic [31:0]        out_pc,
  output logic [31:0]        out_imm,
  output logic [2:0]         out_imm_type,
  output logic               out_illegal,
  output logic [COUNT_W-1:0] stall_cnt
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [2:0] IMM_NONE = 3'd0;
  localparam logic [2:0] IMM_I    = 3'd1;
  localparam logic [2:0] IMM_S    = 3'd2;
  localparam logic [2:0] IMM_B    = 3'd3;
  localparam logic [2:0] IMM_U    = 3'd4;
  localparam logic [2:0] IMM_J    = 3'd5;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [2:0]  imm_type;
    logic        illegal;
  } entry_t;

  state_t             state_q, state_d;
  entry_t             main_q, main_d;
  entry_t             skid_q, skid_d;
  entry_t             dec;
  logic [COUNT_W-1:0] stall_q, stall_d;
  logic               accept;
  logic               pop;

  always_comb begin
    dec          = '0;
    dec.instr    = in_instr;
    dec.pc       = in_pc;
    unique case (in_instr[6:0])
      OP_LUI, OP_AUIPC: begin
        dec.imm_type = IMM_U;
        dec.imm      = {in_instr[31:12], 12'b0};
      end
      OP_JAL: begin
        dec.imm_type = IMM_J;
        dec.imm      = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                        in_instr[20], in_instr[30:21], 1'b0};
      end
      OP_JALR, OP_LOAD, OP_IMM: begin
        dec.imm_type = IMM_I;
        dec.imm      = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      OP_STORE: begin
        dec.imm_type = IMM_S;
        dec.imm      = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      OP_BRANCH: begin
        dec.imm_type = IMM_B;
        dec.imm      = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                        in_instr[30:25], in_instr[11:8], 1'b0};
      end
      OP_REG: begin
        dec.imm_type = IMM_NONE;
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
  end

  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d = ONE;
            main_d  = dec;
          end
        end
        ONE: begin
          if (accept && pop) begin
            main_d = dec;
          end else if (accept) begin
            state_d = FULL;
            skid_d  = dec;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Counts stalls even in a flush cycle; only reset clears it.
  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_ready && (stall_q != {COUNT_W{1'b1}})) begin
      stall_d = stall_q + COUNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      stall_q <= stall_d;
    end
  end

  assign out_instr    = main_q.instr;
  assign out_pc       = main_q.pc;
  assign out_imm      = main_q.imm;
  assign out_imm_type = main_q.imm_type;
  assign out_illegal  = main_q.illegal;
  assign stall_cnt    = stall_q;

endmodule

// File: tb/tb_decode_imm_stage.sv
// Directed bench for decode_imm_stage: decode vector table plus ordering, flush, stall and reset sequences.
module tb_decode_imm_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_imm;
  logic [2:0]  out_imm_type;
  logic        out_illegal;
  logic [1:0]  stall_cnt;

  always #5 clk = ~clk;

  decode_imm_stage #(.COUNT_W(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .in_pc        (in_pc),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_instr    (out_instr),
    .out_pc       (out_pc),
    .out_imm      (out_imm),
    .out_imm_type (out_imm_type),
    .out_illegal  (out_illegal),
    .stall_cnt    (stall_cnt)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm;
    logic [2:0]  typ;
    logic        ill;
  } vec_t;

  vec_t        vecs[14];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] got[$];
  logic [31:0] abc[3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    in_valid = 1'b0;
    flush    = 1'b0;
    reset    = 1'b1;
    tick();
    reset    = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int seen;
    int last_c;
    logic acc;
    logic pp;
    logic [31:0] popped;

    vecs[0]  = '{32'hFFF00093, 32'hFFFFFFFF, 3'd1, 1'b0};
    vecs[1]  = '{32'hFE000EE3, 32'hFFFFFFFC, 3'd3, 1'b0};
    vecs[2]  = '{32'h123450B7, 32'h12345000, 3'd4, 1'b0};
    vecs[3]  = '{32'h0000007F, 32'h00000000, 3'd0, 1'b1};
    vecs[4]  = '{32'h00112423, 32'h00000008, 3'd2, 1'b0};
    vecs[5]  = '{32'hFE112E23, 32'hFFFFFFFC, 3'd2, 1'b0};
    vecs[6]  = '{32'h008000EF, 32'h00000008, 3'd5, 1'b0};
    vecs[7]  = '{32'hFFDFF0EF, 32'hFFFFFFFC, 3'd5, 1'b0};
    vecs[8]  = '{32'h002081B3, 32'h00000000, 3'd0, 1'b0};
    vecs[9]  = '{32'h00412083, 32'h00000004, 3'd1, 1'b0};
    vecs[10] = '{32'h000080E7, 32'h00000000, 3'd1, 1'b0};
    vecs[11] = '{32'hFFFFF117, 32'hFFFFF000, 3'd4, 1'b0};
    vecs[12] = '{32'hFFFFFFFF, 32'h00000000, 3'd0, 1'b1};
    vecs[13] = '{32'h00000863, 32'h00000010, 3'd3, 1'b0};

    abc[0] = 32'h00100093;
    abc[1] = 32'h00200113;
    abc[2] = 32'h00300193;

    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
    in_instr = '0; in_pc = '0; out_ready = 1'b0;

    // Reset values must appear before any clock edge.
    #1 reset = 1'b1;
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_out_imm", out_imm, 32'd0);
    check("rst_imm_type", 32'(out_imm_type), 32'd0);
    check("rst_illegal", 32'(out_illegal), 32'd0);
    check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    tick();
    reset = 1'b0;

    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      in_valid = 1'b1;
      in_instr = vecs[i].instr;
      in_pc    = 32'h1000 + 32'(i * 4);
      tick();
      in_valid = 1'b0;
      check("dec_valid", 32'(out_valid), 32'd1);
      check("dec_instr", out_instr, vecs[i].instr);
      check("dec_pc", out_pc, 32'h1000 + 32'(i * 4));
      check("dec_imm", out_imm, vecs[i].imm);
      check("dec_type", 32'(out_imm_type), 32'(vecs[i].typ));
      check("dec_illegal", 32'(out_illegal), 32'(vecs[i].ill));
      tick();
      check("dec_drained", 32'(out_valid), 32'd0);
    end

    // Back-to-back A, B, C with downstream blocked, then released.
    apply_reset();
    out_ready = 1'b0;
    idx = 0;
    in_valid = 1'b1;
    in_instr = abc[0];
    for (int c = 0; c < 3; c++) begin
      acc = in_valid & in_ready;
      tick();
      if (acc) begin
        idx++;
        if (idx < 3) in_instr = abc[idx];
        else in_valid = 1'b0;
      end
    end
    check("fifo_accepted", 32'(idx), 32'd2);
    check("fifo_full_ready", 32'(in_ready), 32'd0);
    check("fifo_hold_head", out_instr, abc[0]);
    out_ready = 1'b1;
    last_c = -1;
    for (int c = 0; c < 10 && got.size() < 3; c++) begin
      acc    = in_valid & in_ready;
      pp     = out_valid & out_ready;
      popped = out_instr;
      tick();
      if (pp) got.push_back(popped);
      if (acc) begin
        idx++;
        if (idx < 3) in_instr = abc[idx];
        else in_valid = 1'b0;
      end
      if (got.size() == 3) last_c = c;
    end
    check("fifo_count", 32'(got.size()), 32'd3);
    check("fifo_no_gap", 32'(last_c), 32'd2);
    for (int k = 0; k < 3; k++) begin
      if (k < got.size()) check("fifo_order", got[k], abc[k]);
    end
    check("fifo_empty_after", 32'(out_valid), 32'd0);

    // Stall counter saturation, then reset between edges.
    apply_reset();
    check("stall_start", 32'(stall_cnt), 32'd0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = abc[0];
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("stall_two", 32'(stall_cnt), 32'd2);
    tick();
    tick();
    tick();
    check("stall_sat", 32'(stall_cnt), 32'd3);
    check("stall_hold_data", out_instr, abc[0]);
    #2 reset = 1'b1;
    #1;
    check("async_rst_stall", 32'(stall_cnt), 32'd0);
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_ready", 32'(in_ready), 32'd1);
    tick();
    reset = 1'b0;

    // Flush in FULL with an instruction offered.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = abc[0];
    tick();
    in_instr = abc[1];
    tick();
    check("flush_pre_ready", 32'(in_ready), 32'd0);
    in_instr = 32'hDEAD0013;
    flush    = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_ready", 32'(in_ready), 32'd1);
    check("flush_stall_kept", 32'(stall_cnt), 32'd2);
    out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (out_valid) seen++;
    end
    check("flush_dropped", 32'(seen), 32'd0);
    check("flush_stall_after", 32'(stall_cnt), 32'd2);

    // Reset while FULL, then first accept behaves as from EMPTY.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = abc[0];
    tick();
    in_instr = abc[1];
    tick();
    apply_reset();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_instr  = abc[2];
    in_pc     = 32'h0000_2000;
    tick();
    in_valid = 1'b0;
    check("rst_mid_valid", 32'(out_valid), 32'd1);
    check("rst_mid_instr", out_instr, abc[2]);
    check("rst_mid_pc", out_pc, 32'h0000_2000);
    tick();
    check("rst_mid_empty", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
